spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
// - Downstream end of the SPI link: one peripheral on one CS_out line of the SPI controller.
// - Oversamples SCK/CS_n/COPI with its own clk (clk >= 4x SCK frequency). Receives LEN_RX bits LSB-first,
//   then returns LEN_TX bits LSB-first on CIPO. Presents received byte and accepts a response to local logic.
// PARAMETERS
// - LEN_RX      8     bits received per frame (controller -> peripheral)
// - LEN_TX      8     bits transmitted per frame (peripheral -> controller)
// - TX_DEFAULT  8'hFF word sent when no response was loaded (underrun)
// PORTS
// - clk         in   1       peripheral clock
// - rst         in   1       reset; asynchronous, active-high
// - SCK         in   1       serial clock from controller (async to clk)
// - CS_n        in   1       chip select, active-low (async to clk)
// - COPI        in   1       controller-out peripheral-in
// - CIPO        out  1       peripheral-out; drives 0 when not in TX
// - CIPO_oe     out  1       high only in TX state (external tri-state enable)
// - rx_data     out  LEN_RX  last complete received word, held until next completion
// - rx_valid    out  1       1-cycle pulse: rx_data updated
// - tx_data     in   LEN_TX  response word
// - tx_valid    in   1       response offered; accepted when tx_valid && tx_ready
// - tx_ready    out  1       high when response holding register empty
// - tx_underrun out  1       1-cycle pulse: TX started with empty holding register
// - frame_err   out  1       1-cycle pulse: CS_n deasserted mid-frame
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; CIPO=0, CIPO_oe=0, rx_data=0, rx_valid=0, tx_ready=1,
//   tx_underrun=0, frame_err=0; synchronisers cleared to SCK=1, CS_n=1, COPI=0; bit counter=0; hold empty.
// - Sync: SCK, CS_n, COPI each through 2 flops; one extra flop on SCK for edge detect.
//   sck_rise = s_sck & ~s_sck_d; sck_fall = ~s_sck & s_sck_d. Pin-to-detect latency 3 clk.
// - Holding register: tx_valid&&tx_ready loads tx_data, tx_ready->0 next cycle. Emptied (tx_ready->1)
//   when copied to TX shift register. Load accepted in any state.
// - FSM:
//   IDLE: ignore SCK/COPI. s_cs_n==0 -> RX, bit_cnt=0.
//   RX:   on sck_rise: rx_shift <= {s_copi, rx_shift[LEN_RX-1:1]}, bit_cnt++.
//         when bit_cnt reaches LEN_RX: rx_data <= final shift value, rx_valid pulse next cycle;
//         tx_shift <= hold (or TX_DEFAULT + tx_underrun pulse if empty); bit_cnt=0; -> TX.
//   TX:   CIPO_oe=1, CIPO = tx_shift[0]. On sck_fall after first sck_rise in TX: tx_shift >>= 1.
//         On sck_rise: bit_cnt++; at bit_cnt==LEN_TX -> DONE. SCK held high (controller pause) is idle time.
//   DONE: CIPO=0, CIPO_oe=0; wait s_cs_n==1 -> IDLE. Extra SCK edges ignored.
// - s_cs_n==1 in RX or TX: frame_err pulse, -> IDLE, no rx_valid, partial bits discarded, hold untouched
//   (unless already copied to tx_shift: copied word is lost). CS_n rising in DONE is normal, no error.
// - Simultaneous sck_rise and s_cs_n rise: CS_n wins (abort).
// - bit_cnt width = $clog2(max(LEN_RX,LEN_TX)+1); no wrap-around possible.
// - Reset mid-frame: immediate return to reset values; next frame requires CS_n high->low.
// - Frame starting with CS_n already low after reset: treated as start (IDLE sees s_cs_n==0).
// TESTING
// - Load tx 0x3C; frame sends 0xA5 LSB-first (1,0,1,0,0,1,0,1) -> rx_data=0xA5, one rx_valid pulse;
//   CIPO over TX bits = 0,0,1,1,1,1,0,0; tx_ready back to 1.
// - No tx load; frame sends 0x01 -> tx_underrun pulse once, CIPO bits all 1 (0xFF), rx_data=0x01.
// - CS_n raised after 3 SCK rises -> frame_err pulse, no rx_valid, rx_data unchanged, CIPO_oe=0.
// - CS_n high, 16 SCK pulses with COPI toggling -> no rx_valid, CIPO_oe stays 0, state IDLE.
// - Two back-to-back frames 0x5A then 0xC3, tx 0x11 loaded between -> rx_valid x2, rx_data 0x5A then 0xC3;
//   second frame returns 0x11.
// - rst pulsed after 4 RX bits -> all outputs at reset values same cycle; next full frame 0x77 received OK.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI peripheral (mode 0, LSB-first) oversampled by the local clock: receives LEN_RX bits,
// then returns LEN_TX bits from a one-deep response holding register.
module spi_peripheral #(
    parameter int                LEN_RX     = 8,
    parameter int                LEN_TX     = 8,
    parameter logic [LEN_TX-1:0] TX_DEFAULT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              CS_n,
    input  logic              COPI,
    output logic              CIPO,
    output logic              CIPO_oe,
    output logic [LEN_RX-1:0] rx_data,
    output logic              rx_valid,
    input  logic [LEN_TX-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int MAXLEN = (LEN_RX > LEN_TX) ? LEN_RX : LEN_TX;
    localparam int CNT_W  = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

    // Input synchronisers; sck_p2_q is the delayed copy used for edge detection
    logic sck_p0_q, sck_p1_q, sck_p2_q;
    logic cs_p0_q, cs_p1_q;
    logic copi_p0_q, copi_p1_q;

    logic s_sck, s_sck_d, s_cs_n, s_copi;
    logic sck_rise, sck_fall;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_RX-2:0]   rx_part_q, rx_part_d;
    logic [LEN_RX-1:0]   rx_data_q, rx_data_d;
    logic [LEN_RX-1:0]   rx_word;
    logic [LEN_TX-1:0]   tx_shift_q, tx_shift_d;
    logic                tx_started_q, tx_started_d;
    logic [LEN_TX-1:0]   hold_q, hold_d;
    logic                ready_q, ready_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                ferr_q, ferr_d;

    assign s_sck    = sck_p1_q;
    assign s_sck_d  = sck_p2_q;
    assign s_cs_n   = cs_p1_q;
    assign s_copi   = copi_p1_q;
    assign sck_rise = s_sck & ~s_sck_d;
    assign sck_fall = ~s_sck & s_sck_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_part_d    = rx_part_q;
        rx_data_d    = rx_data_q;
        tx_shift_d   = tx_shift_q;
        tx_started_d = tx_started_q;
        hold_d       = hold_q;
        ready_d      = ready_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        ferr_d       = 1'b0;
        rx_word      = {s_copi, rx_part_q};

        if (tx_valid && ready_q) begin
            hold_d  = tx_data;
            ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!s_cs_n) begin
                    state_d = RX;
                    cnt_d   = '0;
                end
            end
            RX: begin
                // CS_n deassertion takes priority over a coincident SCK rise
                if (s_cs_n) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sck_rise) begin
                    rx_part_d = rx_word[LEN_RX-1:1];
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(LEN_RX - 1)) begin
                        rx_data_d    = rx_word;
                        rx_valid_d   = 1'b1;
                        cnt_d        = '0;
                        state_d      = TX;
                        tx_started_d = 1'b0;
                        if (ready_q) begin
                            tx_shift_d = TX_DEFAULT;
                            underrun_d = 1'b1;
                        end else begin
                            tx_shift_d = hold_q;
                            ready_d    = 1'b1;
                        end
                    end
                end
            end
            TX: begin
                if (s_cs_n) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // The fall trailing the last RX bit must not consume TX bit 0
                    if (sck_fall && tx_started_q) begin
                        tx_shift_d = tx_shift_q >> 1;
                    end
                    if (sck_rise) begin
                        tx_started_d = 1'b1;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(LEN_TX - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (s_cs_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_p0_q     <= 1'b1;
            sck_p1_q     <= 1'b1;
            sck_p2_q     <= 1'b1;
            cs_p0_q      <= 1'b1;
            cs_p1_q      <= 1'b1;
            copi_p0_q    <= 1'b0;
            copi_p1_q    <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_part_q    <= '0;
            rx_data_q    <= '0;
            tx_shift_q   <= '0;
            tx_started_q <= 1'b0;
            hold_q       <= '0;
            ready_q      <= 1'b1;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            sck_p0_q     <= SCK;
            sck_p1_q     <= sck_p0_q;
            sck_p2_q     <= sck_p1_q;
            cs_p0_q      <= CS_n;
            cs_p1_q      <= cs_p0_q;
            copi_p0_q    <= COPI;
            copi_p1_q    <= copi_p0_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_part_q    <= rx_part_d;
            rx_data_q    <= rx_data_d;
            tx_shift_q   <= tx_shift_d;
            tx_started_q <= tx_started_d;
            hold_q       <= hold_d;
            ready_q      <= ready_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            ferr_q       <= ferr_d;
        end
    end

    assign CIPO_oe     = (state_q == TX);
    assign CIPO        = (state_q == TX) & tx_shift_q[0];
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ready_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: table of full frames plus hand-written abort, idle-SCK and reset sequences.
module tb_spi_peripheral;

    localparam int H = 6;  // SCK half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       SCK, CS_n, COPI;
    logic       CIPO, CIPO_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_underrun, frame_err;

    spi_peripheral #(.LEN_RX(8), .LEN_TX(8), .TX_DEFAULT(8'hFF)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CS_n(CS_n), .COPI(COPI),
        .CIPO(CIPO), .CIPO_oe(CIPO_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0, u_cnt = 0, fe_cnt = 0;
    logic [7:0] exp_rx_q[$];

    typedef struct {
        logic [7:0] rx_word;
        logic       load;
        logic [7:0] tx_word;
        logic [7:0] exp_cipo;
        int         exp_underrun;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the expected received word on every rx_valid pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rv_cnt++;
                if (exp_rx_q.size() == 0) begin
                    chk("rx_valid_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
                end
            end
            if (tx_underrun) u_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            COPI = w[i];
            wait_clk(H);
            SCK = 1'b1;
            wait_clk(H);
            SCK = 1'b0;
        end
    endtask

    task automatic recv_bits(output logic [7:0] got);
        logic oe_all;
        oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_clk(H);
            got[i] = CIPO;
            oe_all = oe_all & CIPO_oe;
            SCK = 1'b1;
            wait_clk(H);
            SCK = 0;
        end
        chk("cipo_oe_during_tx", 32'(oe_all), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] w, output logic [7:0] got);
        exp_rx_q.push_back(w);
        CS_n = 1'b0;
        wait_clk(H);
        send_bits(w, 8);
        recv_bits(got);
        wait_clk(H);
        CS_n = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic load_tx(input logic [7:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_CIPO"}, 32'(CIPO), 32'd0);
        chk({tag, "_CIPO_oe"}, 32'(CIPO_oe), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] saved;
        logic       oe_seen;
        int u0, r0, f0;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'h3C, 0};
        vecs[1] = '{8'h01, 1'b0, 8'h00, 8'hFF, 1};
        vecs[2] = '{8'h5A, 1'b0, 8'h00, 8'hFF, 1};
        vecs[3] = '{8'hC3, 1'b1, 8'h11, 8'h11, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'h80, 8'h80, 0};
        vecs[5] = '{8'h00, 1'b1, 8'h00, 8'h00, 0};

        rst = 1'b1; SCK = 1'b0; CS_n = 1'b1; COPI = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        wait_clk(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].load) load_tx(vecs[i].tx_word);
            u0 = u_cnt; r0 = rv_cnt; f0 = fe_cnt;
            run_frame(vecs[i].rx_word, got);
            chk($sformatf("cipo_word[%0d]", i), 32'(got), 32'(vecs[i].exp_cipo));
            chk($sformatf("underrun_cnt[%0d]", i), 32'(u_cnt - u0), 32'(vecs[i].exp_underrun));
            chk($sformatf("rx_valid_cnt[%0d]", i), 32'(rv_cnt - r0), 32'd1);
            chk($sformatf("frame_err_cnt[%0d]", i), 32'(fe_cnt - f0), 32'd0);
            chk($sformatf("tx_ready_end[%0d]", i), 32'(tx_ready), 32'd1);
            chk($sformatf("cipo_oe_end[%0d]", i), 32'(CIPO_oe), 32'd0);
        end

        // Abort after 3 bits: hold register must survive for the next frame
        load_tx(8'h42);
        saved = rx_data;
        u0 = u_cnt; r0 = rv_cnt; f0 = fe_cnt;
        CS_n = 1'b0;
        wait_clk(H);
        send_bits(8'hE7, 3);
        wait_clk(H);
        CS_n = 1'b1;
        wait_clk(2 * H);
        chk("abort_frame_err", 32'(fe_cnt - f0), 32'd1);
        chk("abort_rx_valid", 32'(rv_cnt - r0), 32'd0);
        chk("abort_rx_data", 32'(rx_data), 32'(saved));
        chk("abort_cipo_oe", 32'(CIPO_oe), 32'd0);
        chk("abort_tx_ready", 32'(tx_ready), 32'd0);
        run_frame(8'h33, got);
        chk("after_abort_cipo", 32'(got), 32'h42);
        chk("after_abort_underrun", 32'(u_cnt - u0), 32'd0);

        // SCK activity with CS_n high must be ignored
        r0 = rv_cnt; f0 = fe_cnt; oe_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            COPI = i[0];
            wait_clk(3);
            oe_seen = oe_seen | CIPO_oe;
            SCK = 1'b1;
            wait_clk(3);
            oe_seen = oe_seen | CIPO_oe;
            SCK = 1'b0;
        end
        wait_clk(H);
        chk("idle_sck_rx_valid", 32'(rv_cnt - r0), 32'd0);
        chk("idle_sck_oe", 32'(oe_seen), 32'd0);
        chk("idle_sck_frame_err", 32'(fe_cnt - f0), 32'd0);

        // Reset in the middle of RX
        load_tx(8'h99);
        CS_n = 1'b0;
        wait_clk(H);
        send_bits(8'h0F, 4);
        wait_clk(2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        wait_clk(2);
        CS_n = 1'b1;
        rst = 1'b0;
        wait_clk(2 * H);
        u0 = u_cnt; r0 = rv_cnt;
        run_frame(8'h77, got);
        chk("post_rst_cipo", 32'(got), 32'hFF);
        chk("post_rst_underrun", 32'(u_cnt - u0), 32'd1);
        chk("post_rst_rx_valid", 32'(rv_cnt - r0), 32'd1);
        chk("post_rst_rx_data", 32'(rx_data), 32'h77);

        wait_clk(4);
        chk("scoreboard_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
